// File: rtl/stack_display_driver.sv
// Four-digit common-anode seven-segment driver for the processor's stack and instruction-count buses.
// Snapshots a selected 16-bit value and scans its hex nibbles across the digits, with registered pad outputs.
module stack_display_driver #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] top_of_stack,
    input  logic [15:0] second_of_stack,
    input  logic [31:0] inst_count,
    input  logic [1:0]  sel,
    input  logic        freeze,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [15:0]          snap_q, snap_d;
    logic [15:0]          src_val;
    logic [3:0]           nibble;
    logic [6:0]           seg_q, seg_d;
    logic [3:0]           an_q, an_d;
    logic                 dp_q, dp_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        src_val = top_of_stack;
        case (sel)
            2'b00: src_val = top_of_stack;
            2'b01: src_val = second_of_stack;
            2'b10: src_val = inst_count[15:0];
            default: src_val = inst_count[31:16];
        endcase
    end

    // Outputs are built from pre-edge idx/snap so anode and segments always switch together.
    always_comb begin
        cnt_d  = cnt_q + DIV_WIDTH'(1);
        idx_d  = (&cnt_q) ? idx_q + 2'd1 : idx_q;
        snap_d = freeze ? snap_q : src_val;
        nibble = snap_q[4*idx_q +: 4];
        an_d   = ~(4'b0001 << idx_q);
        seg_d  = hex_to_seg(nibble);
        dp_d   = ~((idx_q == 2'd3) && freeze);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            snap_q <= 16'h0000;
            an_q   <= 4'b1111;
            seg_q  <= 7'b1111111;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_stack_display_driver.sv
// Directed bench for stack_display_driver at DIV_WIDTH=2 (4-cycle digit period).
module tb_stack_display_driver;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] top_of_stack;
    logic [15:0] second_of_stack;
    logic [31:0] inst_count;
    logic [1:0]  sel;
    logic        freeze;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int checks   = 0;
    int failures = 0;

    stack_display_driver #(.DIV_WIDTH(2)) dut (
        .CLK             (CLK),
        .reset           (reset),
        .top_of_stack    (top_of_stack),
        .second_of_stack (second_of_stack),
        .inst_count      (inst_count),
        .sel             (sel),
        .freeze          (freeze),
        .seg             (seg),
        .an              (an),
        .dp              (dp)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [15:0] tos;
        logic [15:0] sos;
        logic [31:0] ic;
        logic [1:0]  sl;
        logic        frz;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst, input logic [15:0] tos, input logic [15:0] sos,
                       input logic [31:0] ic, input logic [1:0] sl, input logic frz,
                       input logic [3:0] ea, input logic [6:0] es, input logic ed);
        vec_t v;
        v.rst = rst; v.tos = tos; v.sos = sos; v.ic = ic; v.sl = sl; v.frz = frz;
        v.exp_an = ea; v.exp_seg = es; v.exp_dp = ed;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        int cycles;
        int period;
        reset = 1'b1; top_of_stack = 16'h0; second_of_stack = 16'h0;
        inst_count = 32'h0; sel = 2'b00; freeze = 1'b0;

        // reset held 3 cycles
        add(3, 1, 16'hBEEF, 16'h0, 32'h0, 2'b00, 0, 4'b1111, 7'b1111111, 1);
        // scan 1234
        add(1, 0, 16'h1234, 16'h0, 32'h0, 2'b00, 0, 4'b1110, 7'b1000000, 1);
        add(3, 0, 16'h1234, 16'h0, 32'h0, 2'b00, 0, 4'b1110, 7'b0011001, 1);
        add(4, 0, 16'h1234, 16'h0, 32'h0, 2'b00, 0, 4'b1101, 7'b0110000, 1);
        add(4, 0, 16'h1234, 16'h0, 32'h0, 2'b00, 0, 4'b1011, 7'b0100100, 1);
        add(4, 0, 16'h1234, 16'h0, 32'h0, 2'b00, 0, 4'b0111, 7'b1111001, 1);
        add(4, 0, 16'h1234, 16'h0, 32'h0, 2'b00, 0, 4'b1110, 7'b0011001, 1);
        // inst_count upper half
        add(1, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b11, 0, 4'b1101, 7'b0110000, 1);
        add(3, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b11, 0, 4'b1101, 7'b1000110, 1);
        add(4, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b11, 0, 4'b1011, 7'b0000011, 1);
        add(4, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b11, 0, 4'b0111, 7'b0001000, 1);
        add(4, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b11, 0, 4'b1110, 7'b0100001, 1);
        add(4, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b11, 0, 4'b1101, 7'b1000110, 1);
        // inst_count lower half
        add(1, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b10, 0, 4'b1011, 7'b0000011, 1);
        add(3, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b10, 0, 4'b1011, 7'b0001110, 1);
        add(4, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b10, 0, 4'b0111, 7'b1000000, 1);
        add(4, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b10, 0, 4'b1110, 7'b1000000, 1);
        add(4, 0, 16'h1234, 16'h0, 32'hABCD_0F00, 2'b10, 0, 4'b1101, 7'b1000000, 1);
        // freeze holding 00E0 while input moves to FFFF
        add(1, 0, 16'h00E0, 16'h0, 32'hABCD_0F00, 2'b00, 0, 4'b1011, 7'b0001110, 1);
        add(3, 0, 16'h00E0, 16'h0, 32'hABCD_0F00, 2'b00, 0, 4'b1011, 7'b1000000, 1);
        add(1, 0, 16'h00E0, 16'h0, 32'hABCD_0F00, 2'b00, 1, 4'b0111, 7'b1000000, 0);
        add(3, 0, 16'hFFFF, 16'h0, 32'hABCD_0F00, 2'b00, 1, 4'b0111, 7'b1000000, 0);
        add(4, 0, 16'hFFFF, 16'h0, 32'hABCD_0F00, 2'b00, 1, 4'b1110, 7'b1000000, 1);
        add(4, 0, 16'hFFFF, 16'h0, 32'hABCD_0F00, 2'b00, 1, 4'b1101, 7'b0000110, 1);
        add(4, 0, 16'hFFFF, 16'h0, 32'hABCD_0F00, 2'b00, 1, 4'b1011, 7'b1000000, 1);
        add(4, 0, 16'hFFFF, 16'h0, 32'hABCD_0F00, 2'b00, 1, 4'b0111, 7'b1000000, 0);
        add(1, 0, 16'hFFFF, 16'h0, 32'hABCD_0F00, 2'b00, 0, 4'b1110, 7'b1000000, 1);
        add(3, 0, 16'hFFFF, 16'h0, 32'hABCD_0F00, 2'b00, 0, 4'b1110, 7'b0001110, 1);
        // latency: nibble 0 goes 0 -> 8 while digit 0 is active
        add(4, 0, 16'hFFF0, 16'h0, 32'h0, 2'b00, 0, 4'b1101, 7'b0001110, 1);
        add(4, 0, 16'hFFF0, 16'h0, 32'h0, 2'b00, 0, 4'b1011, 7'b0001110, 1);
        add(4, 0, 16'hFFF0, 16'h0, 32'h0, 2'b00, 0, 4'b0111, 7'b0001110, 1);
        add(1, 0, 16'hFFF0, 16'h0, 32'h0, 2'b00, 0, 4'b1110, 7'b1000000, 1);
        add(1, 0, 16'hFFF8, 16'h0, 32'h0, 2'b00, 0, 4'b1110, 7'b1000000, 1);
        add(2, 0, 16'hFFF8, 16'h0, 32'h0, 2'b00, 0, 4'b1110, 7'b0000000, 1);
        add(4, 0, 16'hFFF8, 16'h0, 32'h0, 2'b00, 0, 4'b1101, 7'b0001110, 1);
        add(2, 0, 16'hFFF8, 16'h0, 32'h0, 2'b00, 0, 4'b1011, 7'b0001110, 1);
        // mid-scan reset (with freeze high, which reset must override)
        add(1, 1, 16'hFFF8, 16'h0, 32'h0, 2'b00, 1, 4'b1111, 7'b1111111, 1);
        add(1, 0, 16'hFFF8, 16'h0, 32'h0, 2'b00, 0, 4'b1110, 7'b1000000, 1);
        add(3, 0, 16'hFFF8, 16'h0, 32'h0, 2'b00, 0, 4'b1110, 7'b0000000, 1);
        add(1, 0, 16'hFFF8, 16'h0, 32'h0, 2'b00, 0, 4'b1101, 7'b0001110, 1);
        // second_of_stack source
        add(1, 0, 16'hFFF8, 16'h5678, 32'h0, 2'b01, 0, 4'b1101, 7'b0001110, 1);
        add(2, 0, 16'hFFF8, 16'h5678, 32'h0, 2'b01, 0, 4'b1101, 7'b1111000, 1);
        add(1, 0, 16'hFFF8, 16'h5678, 32'h0, 2'b01, 0, 4'b1011, 7'b0000010, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            reset           = vecs[i].rst;
            top_of_stack    = vecs[i].tos;
            second_of_stack = vecs[i].sos;
            inst_count      = vecs[i].ic;
            sel             = vecs[i].sl;
            freeze          = vecs[i].frz;
            @(posedge CLK);
            #1;
            check("an",  i, 32'(an),  32'(vecs[i].exp_an));
            check("seg", i, 32'(seg), 32'(vecs[i].exp_seg));
            check("dp",  i, 32'(dp),  32'(vecs[i].exp_dp));
        end

        // digit 3 must stay lit for exactly 4 cycles, then hand over to digit 0
        cycles = 0;
        while (an !== 4'b0111 && cycles < 40) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        check("wait_digit3", 0, 32'(an), 32'(4'b0111));
        if (an === 4'b0111) begin
            period = 1;
            while (cycles < 60) begin
                @(posedge CLK);
                #1;
                cycles++;
                if (an !== 4'b0111) break;
                period++;
            end
            check("digit_period", 0, 32'(period), 32'd4);
            check("after_digit3", 0, 32'(an), 32'(4'b1110));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
